// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub over one full-adder cell; LSB first, result valid WIDTH edges after accept.
// Input is refused while busy; result, cout and ovf are held in DONE until out_ready.

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   fa_cell u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         sa        <= '0;
         sb        <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1: the +1 rides in on the initial carry.
                  sa       <= op_a;
                  sb       <= sub ? ~op_b : op_b;
                  carry    <= sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               result <= {fa_s, result[WIDTH-1:1]};
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB on this step
                  cout      <= fa_co;
                  ovf       <= carry ^ fa_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: vector table plus handshake/reset sequences.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } vec_t;

   vec_t vt[10];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present a pair at the negedge; it is taken on the following posedge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges after the accepting edge until out_valid; -1 if it never shows up.
   task automatic wait_done(input bit scramble, output int lat);
      lat = -1;
      for (int i = 1; i <= W + 4; i++) begin
         if (scramble) begin
            op_a = W'($urandom); op_b = W'($urandom);
            sub = 1'($urandom); in_valid = 1'($urandom);
         end
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
   endtask

   task automatic check_result(input string tag, input vec_t v, input int lat);
      check({tag, "_latency"}, lat, W);
      check({tag, "_result"}, result, v.r);
      check({tag, "_cout"}, cout, v.c);
      check({tag, "_ovf"}, ovf, v.v);
   endtask

   initial begin
      int   lat;
      int   seen;
      vec_t v;

      vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
      vt[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
      vt[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[9] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);

      foreach (vt[i]) begin
         accept(vt[i].a, vt[i].b, vt[i].s);
         check("accept_busy", busy, 1);
         check("accept_in_ready", in_ready, 0);
         wait_done(1'b0, lat);
         check_result($sformatf("vec%0d", i), vt[i], lat);
         release_out();
      end

      // Backpressure: everything held while out_ready stays low.
      accept(8'h5A, 8'h3C, 1'b0);
      wait_done(1'b0, lat);
      check_result("bp", vt[0], lat);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp_result", result, 8'h96);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      release_out();

      // Operand and control churn during RUN must not disturb the sampled pair.
      accept(8'h12, 8'h34, 1'b0);
      wait_done(1'b1, lat);
      v = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      check_result("stab", v, lat);

      // in_valid and out_ready together in DONE: only the output side completes.
      op_a = 8'h7F; op_b = 8'h01; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("both_out_valid", out_valid, 0);
      check("both_busy", busy, 0);
      check("both_in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("both_accept_busy", busy, 1);
      wait_done(1'b0, lat);
      check_result("both", vt[4], lat);
      release_out();

      // Asynchronous reset three edges into RUN.
      accept(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_result", result, 0);
      check("arst_cout", cout, 0);
      check("arst_ovf", ovf, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < W + 3; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("arst_no_valid", seen, 0);
      accept(8'h01, 8'h01, 1'b0);
      wait_done(1'b0, lat);
      v = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
      check_result("post_rst", v, lat);
      release_out();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and steps the full adder LSB-first, one bit per clock, through a registered carry.
- Presents the result, carry-out and signed overflow over a second valid/ready handshake.
- Serves as the low-area arithmetic unit for control paths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and sub are valid.
- in_ready  out  1  block can accept an operand pair.
- op_a  in  WIDTH  first operand.
- op_b  in  WIDTH  second operand.
- sub  in  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  out  1  result, cout and ovf are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow.
- busy  out  1  high in RUN and DONE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low immediately forces:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0, busy = 0
  - result = 0, cout = 0, ovf = 0
  - internal shift registers, carry flop and bit counter = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid=1, latch op_a into shift register SA.
  - Latch op_b into SB, inverted when sub=1.
  - Set the carry flop to sub, counter = 0, then go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle the full-adder cell takes SA[0], SB[0] and the carry flop.
  - At the edge:
    - sum bit shifts into result from the MSB side (result shifts right), so after WIDTH shifts result[0] holds bit 0.
    - SA and SB shift right; carry flop takes the cell carry; counter increments.
  - When counter == WIDTH-1:
    - Capture the carry-in of this (MSB) step as cmsb.
    - On the same edge: cout = cell carry, ovf = cmsb XOR cell carry, state -> DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result, cout and ovf are held stable while out_ready = 0, for any number of cycles.
  - On an edge with out_ready=1: out_valid -> 0, state -> IDLE.
  - result, cout and ovf keep their last values in IDLE.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum accept-to-accept spacing is WIDTH+2 edges; no back-to-back overlap.
- Arithmetic:
  - result = (op_a + (sub ? ~op_b : op_b) + sub) mod 2^WIDTH.
  - All operands are unsigned bit vectors; ovf interprets them as two's-complement.
- Boundaries:
  - Operands are sampled only on the accepting edge; later changes on op_a, op_b or sub have no effect.
  - out_ready while not in DONE is ignored.
  - in_valid and out_ready both high in DONE: only the output handshake completes. The new pair is accepted in IDLE on the next edge if in_valid is still high.
  - rst_n asserted in RUN or DONE aborts the operation; no partial result is ever flagged valid.
  - Deassertion of rst_n returns to IDLE behaviour on the first subsequent edge.
- Exactly one full-adder cell instance performs all arithmetic; no WIDTH-bit adder is inferred.

Test Plan:
- Reset check: hold rst_n low for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, result=0x00, cout=0, ovf=0.
- WIDTH=8, add 0x5A+0x3C -> after 8 edges out_valid=1, result=0x96, cout=0, ovf=1. Then 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
- Subtract 0x10-0x20 -> result=0xF0, cout=0, ovf=0. Subtract 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE after 0x5A+0x3C -> result stays 0x96 and out_valid stays 1, with in_ready=0. Raise out_ready -> out_valid=0 next edge and in_ready=1.
- Operand stability: toggle op_a, op_b, sub and in_valid randomly during RUN for 0x12+0x34 -> result=0x46, cout=0, ovf=0.
- Reset mid-operation: pulse rst_n low asynchronously after 3 RUN edges -> outputs return to reset values immediately and out_valid never asserts. Then 0x01+0x01 -> result=0x02.
